spi_ram_param: RTL and testbench

- Parametrised single-port command-driven RAM behind the SPI slave; next generation of the fixed 8-bit/256-deep SPI RAM.
- Consumes {cmd, payload} words from the SPI slave (rx_valid) and returns read data (tx_valid) to it.
- Generalised in data width, address width, depth and read latency.
- Adds write-address auto-increment and an out-of-range address error pulse.

---
 rtl/spi_ram_pkg.sv | 10 +
 rtl/spi_ram_rd_pipe.sv | 36 +++
 rtl/spi_ram_param.sv | 64 ++++++
 tb/tb_spi_ram_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encoding shared by the SPI RAM blocks
package spi_ram_pkg;
  localparam int CMD_W = 2;
  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;
endpackage

// File: rtl/spi_ram_rd_pipe.sv
// spi_ram_rd_pipe: read-response delay line carrying {valid, data, err} to the outputs
module spi_ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              e_in,
  output logic              tx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              err
);
  logic [RD_LAT-1:0] v, e;
  logic [DATA_W-1:0] d [RD_LAT];
  // Shift stages; data only moves with a valid token so dout holds between reads
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int k = 0; k < RD_LAT; k++) d[k] <= '0;
    end else begin
      v[0] <= v_in;
      e[0] <= e_in;
      if (v_in) d[0] <= d_in;
      for (int k = 1; k < RD_LAT; k++) begin
        v[k] <= v[k-1];
        e[k] <= e[k-1];
        if (v[k-1]) d[k] <= d[k-1];
      end
    end
  assign tx_valid = v[RD_LAT-1];
  assign dout     = d[RD_LAT-1];
  assign err      = e[RD_LAT-1];
endmodule

// File: rtl/spi_ram_param.sv
// spi_ram_param: parametrised command-driven RAM behind an SPI slave
module spi_ram_param
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT    = 1,
  parameter int AUTO_INC  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W+CMD_W-1:0] din,
  input  logic                    rx_valid,
  output logic [DATA_W-1:0]       dout,
  output logic                    tx_valid,
  output logic                    addr_err
);
  if (ADDR_W > DATA_W || MEM_DEPTH > 2**ADDR_W || (RD_LAT != 1 && RD_LAT != 2)) begin : g_bad_params
    $error("spi_ram_param: illegal parameter combination");
  end
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  cmd_e              cmd;
  logic [DATA_W-1:0] pay, rd_data;
  logic [ADDR_W-1:0] pay_a, wr_addr, rd_addr;
  logic [ADDR_W:0]   wr_nxt;
  logic              wr_oor, rd_oor, wr_go, rd_go, wr_err, rd_err;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  assign cmd     = cmd_e'(din[DATA_W+CMD_W-1:DATA_W]);
  assign pay     = din[DATA_W-1:0];
  assign pay_a   = pay[ADDR_W-1:0];
  assign wr_oor  = {1'b0, wr_addr} >= DEPTH;
  assign rd_oor  = {1'b0, rd_addr} >= DEPTH;
  assign wr_go   = rx_valid && cmd == CMD_WR_DATA;
  assign rd_go   = rx_valid && cmd == CMD_RD_DATA;
  assign wr_nxt  = {1'b0, wr_addr} + (ADDR_W+1)'(1);
  assign rd_data = rd_oor ? '0 : mem[rd_addr];
  // Address registers, auto-increment with wrap, and the write-error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_go && wr_oor;
      if (rx_valid && cmd == CMD_WR_ADDR) wr_addr <= pay_a;
      else if (wr_go && !wr_oor && AUTO_INC != 0) wr_addr <= wr_nxt == DEPTH ? '0 : wr_nxt[ADDR_W-1:0];
      if (rx_valid && cmd == CMD_RD_ADDR) rd_addr <= pay_a;
    end
  // Storage is deliberately left out of reset so contents survive rst
  always_ff @(posedge clk)
    if (wr_go && !wr_oor) mem[wr_addr] <= pay;
  spi_ram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .v_in    (rd_go),
    .d_in    (rd_data),
    .e_in    (rd_go && rd_oor),
    .tx_valid(tx_valid),
    .dout    (dout),
    .err     (rd_err)
  );
  assign addr_err = rd_err | wr_err;
endmodule

// File: tb/tb_spi_ram_param.sv
// tb_spi_ram_param: three parameterisations driven by one command stream, checked against a cycle-indexed model
module tb_spi_ram_param;
  localparam int DEP[3] = '{256, 200, 1024};
  localparam int LAT[3] = '{1, 2, 1};
  localparam int INC[3] = '{0, 1, 1};
  localparam int DM[3]  = '{'hFF, 'hFF, 'hFFFF};
  localparam int AM[3]  = '{'hFF, 'hFF, 'h3FF};
  logic clk = 0, rst = 1, rx_valid = 0;
  logic [9:0]  din_a = '0;
  logic [17:0] din_c = '0;
  logic [7:0]  dout_a, dout_b;
  logic [15:0] dout_c;
  logic        tv_a, tv_b, tv_c, ae_a, ae_b, ae_c;
  logic        tv[3], ae[3];
  logic [15:0] dx[3];
  int  mm[3][1024], sd[3][1024];
  bit  mk[3][1024], sv[3][1024], se[3][1024], sk[3][1024];
  int  wa[3], ra[3], ed[3];
  bit  ek[3];
  int  cyc = 0, errors = 0, checks = 0;
  initial forever #5 clk = ~clk;
  spi_ram_param #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .RD_LAT(1), .AUTO_INC(0)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .rx_valid(rx_valid), .dout(dout_a), .tx_valid(tv_a), .addr_err(ae_a));
  spi_ram_param #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .RD_LAT(2), .AUTO_INC(1)) u_b (
    .clk(clk), .rst(rst), .din(din_a), .rx_valid(rx_valid), .dout(dout_b), .tx_valid(tv_b), .addr_err(ae_b));
  spi_ram_param #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024), .RD_LAT(1), .AUTO_INC(1)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .rx_valid(rx_valid), .dout(dout_c), .tx_valid(tv_c), .addr_err(ae_c));
  assign tv[0] = tv_a;
  assign tv[1] = tv_b;
  assign tv[2] = tv_c;
  assign ae[0] = ae_a;
  assign ae[1] = ae_b;
  assign ae[2] = ae_c;
  assign dx[0] = {8'h00, dout_a};
  assign dx[1] = {8'h00, dout_b};
  assign dx[2] = dout_c;
  task automatic check(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h, want 0x%0h", nm, i, cyc, act, exp);
    end
  endtask
  // one clock: step to the falling edge, then compare every instance against the schedule
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ed[i] = 0;
        ek[i] = 1;
      end else if (sv[i][cyc]) begin
        ed[i] = sd[i][cyc];
        ek[i] = sk[i][cyc];
      end
      check("tx_valid", i, int'(tv[i]), rst ? 0 : int'(sv[i][cyc]));
      check("addr_err", i, int'(ae[i]), rst ? 0 : int'(se[i][cyc]));
      if (ek[i]) check("dout", i, int'(dx[i]), ed[i]);
    end
  endtask
  // issue one command and record what each instance must do at the coming edge
  task automatic send(input int c, input int p);
    int n, t, pd, a;
    din_a = {c[1:0], p[7:0]};
    din_c = {c[1:0], p[15:0]};
    rx_valid = 1;
    n = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      pd = p & DM[i];
      a  = pd & AM[i];
      if (c == 0) wa[i] = a;
      else if (c == 1) begin
        if (wa[i] >= DEP[i]) se[i][n] = 1;
        else begin
          mm[i][wa[i]] = pd;
          mk[i][wa[i]] = 1;
          if (INC[i] != 0) wa[i] = (wa[i] + 1 == DEP[i]) ? 0 : wa[i] + 1;
        end
      end else if (c == 2) ra[i] = a;
      else begin
        t = n + LAT[i] - 1;
        sv[i][t] = 1;
        if (ra[i] >= DEP[i]) begin
          sd[i][t] = 0;
          sk[i][t] = 1;
          se[i][t] = 1;
        end else begin
          sd[i][t] = mm[i][ra[i]];
          sk[i][t] = mk[i][ra[i]];
        end
      end
    end
    tick();
  endtask
  task automatic idle(input int n);
    rx_valid = 0;
    repeat (n) tick();
  endtask
  task automatic do_reset(input int n);
    #2;
    rx_valid = 0;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      wa[i] = 0;
      ra[i] = 0;
      for (int k = 0; k < 1024; k++) begin
        sv[i][k] = 0;
        se[i][k] = 0;
      end
    end
    repeat (n) tick();
    #2;
    rst = 0;
  endtask
  initial begin
    do_reset(2);
    idle(5);
    send(0, 'h10); send(1, 'hA5); send(2, 'h10); send(3, 0);
    check("lat1_tv", 0, int'(tv_a), 1);
    check("lat1_dout", 0, int'(dout_a), 'hA5);
    check("lat2_early", 1, int'(tv_b), 0);
    check("w16_dout", 2, int'(dout_c), 'hA5);
    idle(1);
    check("lat2_tv", 1, int'(tv_b), 1);
    check("lat2_dout", 1, int'(dout_b), 'hA5);
    check("lat1_once", 0, int'(tv_a), 0);
    idle(2);
    send(0, 0); send(1, 'h5A5A); send(0, 1); send(1, 'h6B6B);
    send(0, 'hC7); send(1, 'h11); send(1, 'h22); send(1, 'h33);
    send(2, 'hC7); send(3, 0); send(2, 0); send(3, 0); send(2, 1); send(3, 0);
    idle(3);
    check("wrap_last", 1, int'(dout_b), 'h33);
    check("noinc_last", 0, int'(dout_a), 'h6B);
    check("inc16_last", 2, int'(dout_c), 'h6B6B);
    send(0, 'h3FF); send(1, 'hBEEF); send(1, 'h1234); send(2, 'h3FF); send(3, 0);
    check("beef", 2, int'(dout_c), 'hBEEF);
    check("trunc", 0, int'(dout_a), 'h34);
    idle(2);
    send(2, 0); send(3, 0);
    check("wrap1024", 2, int'(dout_c), 'h1234);
    idle(2);
    send(0, 'hC8); send(1, 'h55);
    check("wr_err", 1, int'(ae_b), 1);
    check("wr_ok", 0, int'(ae_a), 0);
    send(2, 'hC8); send(3, 0);
    idle(1);
    check("oor_tv", 1, int'(tv_b), 1);
    check("oor_dout", 1, int'(dout_b), 0);
    check("oor_err", 1, int'(ae_b), 1);
    idle(2);
    send(2, 'h10); send(3, 0); send(2, 0); send(3, 0);
    send(2, 1); send(3, 0); send(2, 'hC7); send(3, 0);
    send(3, 0); send(3, 0); send(3, 0);
    idle(3);
    send(2, 'h10); send(3, 0); idle(2); send(3, 0); idle(3);
    send(2, 'h10); send(3, 0);
    do_reset(1);
    idle(5);
    check("rst_drop", 1, int'(tv_b), 0);
    check("rst_dout", 1, int'(dout_b), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
